port_parse_gen: RTL and testbench

- Per-port header parser; generates port-parser-input (ppi) lookup requests for the bridge FIB lookup.
- Observes a byte-wide packet stream from a port receive FIFO and forwards it unchanged to the packet buffer.
- Extracts destination MAC (DA) and source MAC (SA) from each packet and presents one {port, SA, DA} record per packet on an srdy/drdy interface.
- One instance per bridge port; an external arbiter merges the instances ahead of fib_lookup.

---
 rtl/port_parse_gen_if.sv | 31 +++
 rtl/port_parse_gen.sv | 140 ++++++++++++++
 tb/tb_port_parse_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/port_parse_gen_if.sv
// Stream and record handshake bundle for one bridge-port header parser.
//   c_*   : byte stream from the port receive FIFO (srdy/drdy)
//   p_*   : same stream forwarded to the packet buffer (srdy/drdy)
//   ppi_* : {port, SA, DA} lookup record toward the FIB arbiter (srdy/drdy)
// master = parser side, slave = environment side.
interface port_parse_gen_if #(
    parameter int PORT_W      = 2,
    parameter int PAR_DATA_SZ = 96 + PORT_W
);
    logic                   c_srdy;
    logic                   c_drdy;
    logic [7:0]             c_data;
    logic [1:0]             c_code;
    logic                   p_srdy;
    logic                   p_drdy;
    logic [7:0]             p_data;
    logic [1:0]             p_code;
    logic                   ppi_srdy;
    logic                   ppi_drdy;
    logic [PAR_DATA_SZ-1:0] ppi_data;

    modport master (
        input  c_srdy, c_data, c_code, p_drdy, ppi_drdy,
        output c_drdy, p_srdy, p_data, p_code, ppi_srdy, ppi_data
    );

    modport slave (
        output c_srdy, c_data, c_code, p_drdy, ppi_drdy,
        input  c_drdy, p_srdy, p_data, p_code, ppi_srdy, ppi_data
    );
endinterface

// File: rtl/port_parse_gen.sv
// Per-port header parser. Forwards the receive byte stream to the packet
// buffer with no added latency and captures DA/SA from each packet into a
// single-entry {port, SA, DA} record register for the FIB lookup arbiter.
//   clk      : clock
//   reset    : asynchronous active-high reset
//   bus      : c_* in stream, p_* forwarded stream, ppi_* record (master side)
//   runt_err : one-cycle pulse, packet ended before 12 bytes
//   sop_err  : one-cycle pulse, stray byte in IDLE or SOP inside a packet
module port_parse_gen #(
    parameter int PORT_W      = 2,
    parameter int PORT_NUM    = 0,
    parameter int PAR_DATA_SZ = 98
) (
    input  logic                    clk,
    input  logic                    reset,
    port_parse_gen_if.master        bus,
    output logic                    runt_err,
    output logic                    sop_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    localparam logic [PORT_W-1:0] PORT_VAL = PORT_W'(PORT_NUM);

    state_t                 state;
    logic [3:0]             count;
    logic [87:0]            hdr;        // bytes 0..10, byte 0 in the top lane
    logic                   ppi_srdy;
    logic [PAR_DATA_SZ-1:0] ppi_data;

    logic is_sop;
    logic is_eop;
    logic discard;
    logic stall;
    logic fwd_ok;
    logic xfer_in;

    assign is_sop = bus.c_code[0];
    assign is_eop = bus.c_code[1];

    // A SOP always restarts the header, so it never waits on the record slot.
    assign discard = (state == IDLE) && !is_sop;
    assign stall   = (state == HDR) && (count == 4'd11) && !is_sop
                     && ppi_srdy && !bus.ppi_drdy;
    assign fwd_ok  = !stall;

    always_comb begin
        bus.p_data = bus.c_data;
        bus.p_code = bus.c_code;
        bus.p_srdy = 1'b0;
        bus.c_drdy = 1'b1;
        if (!discard) begin
            bus.p_srdy = bus.c_srdy && fwd_ok;
            bus.c_drdy = bus.p_drdy && fwd_ok;
        end
    end

    assign xfer_in      = bus.c_srdy && bus.c_drdy;
    assign bus.ppi_srdy = ppi_srdy;
    assign bus.ppi_data = ppi_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            hdr      <= '0;
            ppi_srdy <= 1'b0;
            ppi_data <= '0;
            runt_err <= 1'b0;
            sop_err  <= 1'b0;
        end else begin
            runt_err <= 1'b0;
            sop_err  <= 1'b0;

            // A load below overrides this clear.
            if (ppi_srdy && bus.ppi_drdy) begin
                ppi_srdy <= 1'b0;
            end

            if (xfer_in) begin
                if (is_sop) begin
                    if (state != IDLE) begin
                        sop_err <= 1'b1;
                    end
                    hdr <= {hdr[79:0], bus.c_data};
                    if (is_eop) begin
                        runt_err <= 1'b1;
                        state    <= IDLE;
                        count    <= 4'd0;
                    end else begin
                        state <= HDR;
                        count <= 4'd1;
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            sop_err <= 1'b1;
                        end
                        HDR: begin
                            if (count == 4'd11) begin
                                // DA = bytes 0..5, SA = bytes 6..10 plus this byte.
                                ppi_data <= {PORT_VAL, hdr[39:0], bus.c_data, hdr[87:40]};
                                ppi_srdy <= 1'b1;
                                if (is_eop) begin
                                    state <= IDLE;
                                    count <= 4'd0;
                                end else begin
                                    state <= BODY;
                                    count <= 4'd12;
                                end
                            end else if (is_eop) begin
                                runt_err <= 1'b1;
                                state    <= IDLE;
                                count    <= 4'd0;
                            end else begin
                                hdr   <= {hdr[79:0], bus.c_data};
                                count <= count + 4'd1;
                            end
                        end
                        BODY: begin
                            if (is_eop) begin
                                state <= IDLE;
                                count <= 4'd0;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            count <= 4'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_port_parse_gen.sv
module tb_port_parse_gen;

    localparam int PORT_W      = 2;
    localparam int PORT_NUM    = 2;
    localparam int PAR_DATA_SZ = 98;

    logic clk;
    logic reset;
    logic runt_err;
    logic sop_err;

    port_parse_gen_if #(.PORT_W(PORT_W), .PAR_DATA_SZ(PAR_DATA_SZ)) bus ();

    port_parse_gen #(
        .PORT_W      (PORT_W),
        .PORT_NUM    (PORT_NUM),
        .PAR_DATA_SZ (PAR_DATA_SZ)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .runt_err (runt_err),
        .sop_err  (sop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int runt_cnt = 0;
    int sop_cnt  = 0;
    bit rand_p    = 1'b0;
    bit mirror_en = 1'b0;

    logic [9:0]             exp_q[$];
    logic [PAR_DATA_SZ-1:0] rec_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PAR_DATA_SZ-1:0] mk_rec(input logic [47:0] da, input logic [47:0] sa);
        logic [PORT_W-1:0] pn;
        pn = PORT_W'(PORT_NUM);
        return {pn, sa, da};
    endfunction

    // Forwarded-stream ready: either held high or randomly toggled.
    always @(posedge clk) begin
        #1;
        bus.p_drdy = rand_p ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.p_srdy && bus.p_drdy) begin
            if (exp_q.size() == 0) begin
                chk("p_unexpected", {bus.p_code, bus.p_data}, 10'h3ff);
            end else begin
                chk("p_byte", {bus.p_code, bus.p_data}, exp_q.pop_front());
            end
        end
        if (bus.ppi_srdy && bus.ppi_drdy) begin
            if (rec_q.size() == 0) begin
                chk("ppi_unexpected", bus.ppi_data, '1);
            end else begin
                chk("ppi_rec", bus.ppi_data, rec_q.pop_front());
            end
        end
        if (mirror_en && bus.c_srdy) begin
            chk("t5_mirror", bus.c_drdy, bus.p_drdy);
        end
        if (runt_err) runt_cnt++;
        if (sop_err)  sop_cnt++;
    end

    task automatic send_byte(input logic [7:0] d, input logic [1:0] code, input bit fwd);
        bit ok;
        ok = 1'b0;
        bus.c_srdy = 1'b1;
        bus.c_data = d;
        bus.c_code = code;
        if (fwd) exp_q.push_back({code, d});
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (bus.c_drdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("byte_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.c_srdy = 1'b0;
    endtask

    task automatic send_pkt(input logic [47:0] da, input logic [47:0] sa, input int len, input bit chk_lat);
        logic [7:0] b;
        logic [1:0] code;
        for (int i = 0; i < len; i++) begin
            if (i < 6)       b = da[47-8*i -: 8];
            else if (i < 12) b = sa[47-8*(i-6) -: 8];
            else             b = 8'(i);
            code = {(i == len - 1), (i == 0)};
            if (i == 11) rec_q.push_back(mk_rec(da, sa));
            send_byte(b, code, 1'b1);
            if (chk_lat && i == 10) chk("ppi_srdy_early", bus.ppi_srdy, 0);
            if (chk_lat && i == 11) chk("ppi_srdy_lat", bus.ppi_srdy, 1);
        end
    endtask

    task automatic drain(input string tag);
        repeat (20) @(posedge clk);
        #1;
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_recs_left"}, rec_q.size(), 0);
    endtask

    localparam logic [47:0] DA1 = 48'h010203040506;
    localparam logic [47:0] SA1 = 48'h0A0B0C0D0E0F;

    initial begin
        int r0;
        int s0;
        bit seen;

        reset        = 1'b1;
        bus.c_srdy   = 1'b0;
        bus.c_data   = 8'h00;
        bus.c_code   = 2'b00;
        bus.ppi_drdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ppi_srdy", bus.ppi_srdy, 0);
        chk("rst_ppi_data", bus.ppi_data, 0);
        chk("rst_runt", runt_err, 0);
        chk("rst_sop", sop_err, 0);
        chk("rst_c_drdy", bus.c_drdy, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: basic 64-byte packet
        send_pkt(DA1, SA1, 64, 1'b1);
        drain("t1");
        chk("t1_runt", runt_cnt, 0);
        chk("t1_sop", sop_cnt, 0);

        // 2: record slot held, second packet stalls at byte 11
        bus.ppi_drdy = 1'b0;
        fork
            begin
                send_pkt(48'h111111111111, 48'h222222222222, 20, 1'b0);
                send_pkt(48'h333333333333, 48'h444444444444, 20, 1'b0);
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (bus.c_srdy && !bus.c_drdy) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("t2_stall_seen", seen, 1);
                chk("t2_ppi_held", bus.ppi_srdy, 1);
                chk("t2_ppi_data", bus.ppi_data, mk_rec(48'h111111111111, 48'h222222222222));
                repeat (3) begin
                    @(negedge clk);
                    chk("t2_stall_cdrdy", bus.c_drdy, 0);
                    chk("t2_stall_srdy", bus.ppi_srdy, 1);
                end
                @(posedge clk);
                #1;
                bus.ppi_drdy = 1'b1;
                @(negedge clk);
                chk("t2_release", bus.c_drdy, 1);
                @(posedge clk);
                #1;
                chk("t2_srdy_kept", bus.ppi_srdy, 1);
                chk("t2_rec2_data", bus.ppi_data, mk_rec(48'h333333333333, 48'h444444444444));
            end
        join
        drain("t2");

        // 3: runts
        r0 = runt_cnt;
        send_pkt(DA1, SA1, 8, 1'b0);
        chk("t3_runt_pulse", runt_err, 1);
        @(posedge clk);
        #1;
        chk("t3_runt_one_cycle", runt_err, 0);
        send_byte(8'h5A, 2'b11, 1'b1);
        chk("t3_runt_single", runt_err, 1);
        drain("t3");
        chk("t3_runt_count", runt_cnt - r0, 2);
        chk("t3_no_rec", bus.ppi_srdy, 0);

        // 4: stray bytes, then SOP restart mid-header
        s0 = sop_cnt;
        send_byte(8'hA1, 2'b00, 1'b0);
        chk("t4_stray0", sop_err, 1);
        send_byte(8'hA2, 2'b00, 1'b0);
        chk("t4_stray1", sop_err, 1);
        send_byte(8'hA3, 2'b10, 1'b0);
        chk("t4_stray2", sop_err, 1);
        send_byte(8'hC0, 2'b01, 1'b1);
        for (int i = 1; i < 5; i++) send_byte(8'(8'hC0 + i), 2'b00, 1'b1);
        send_pkt(48'h5E5E5E5E5E01, 48'h5E5E5E5E5E02, 16, 1'b1);
        drain("t4");
        chk("t4_sop_count", sop_cnt - s0, 4);

        // 5: random forward back-pressure
        rand_p    = 1'b1;
        mirror_en = 1'b1;
        send_pkt(DA1, SA1, 100, 1'b0);
        mirror_en = 1'b0;
        rand_p    = 1'b0;
        drain("t5");

        // 6: reset inside a header
        for (int i = 0; i < 8; i++) send_byte(8'(8'h70 + i), (i == 0) ? 2'b01 : 2'b00, 1'b1);
        bus.c_srdy = 1'b1;
        bus.c_data = 8'h78;
        bus.c_code = 2'b00;
        reset      = 1'b1;
        @(negedge clk);
        chk("t6_srdy_in_rst", bus.ppi_srdy, 0);
        @(posedge clk);
        #1;
        bus.c_srdy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_srdy_after_rst", bus.ppi_srdy, 0);
        send_pkt(48'hABCDEF012345, 48'h6789ABCDEF01, 16, 1'b1);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
